// File: rtl/load_store_queue_pkg.sv
// Shared types for the load/store queue: memory sizes, bus commands,
// queue entry layout and controller states.
package load_store_queue_pkg;

    localparam int XLEN      = 32;
    localparam int LSQ_TAG_W = 5;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        DOUBLE = 3'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic                 unsigned_ld;
        logic [2:0]           size;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      data;
        logic [LSQ_TAG_W-1:0] tag;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        LSQ_IDLE,
        LSQ_WAIT,
        LSQ_DRAIN
    } lsq_state_t;

endpackage

// File: rtl/load_store_queue_extend.sv
// Load data extension: selects the low byte/half/word of the cache data and
// sign- or zero-extends it to XLEN; DOUBLE (and unknown sizes) pass through.
module load_data_extend
    import load_store_queue_pkg::*;
(
    input  logic [XLEN-1:0] raw_data,
    input  logic [2:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] ext_data
);

    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;

    // Pick the field width and its sign bit, then fill the upper bits.
    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            BYTE: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = raw_data[7];
            end
            HALF: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = raw_data[15];
            end
            WORD: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = raw_data[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        ext_data = (raw_data & keep_mask) | ({XLEN{sign_bit & ~is_unsigned}} & ~keep_mask);
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue. Issues one request at a time to the D-cache,
// holds it until the cache completes, then broadcasts loads on the CDB or
// reports store completion to the ROB.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int LSQ_DEPTH = 8,
    parameter int TAG_W     = LSQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  logic             dispatch_is_store,
    input  logic [2:0]       dispatch_size,
    input  logic             dispatch_unsigned,
    input  logic [XLEN-1:0]  dispatch_addr,
    input  logic [XLEN-1:0]  dispatch_data,
    input  logic [TAG_W-1:0] dispatch_tag,
    output logic             lsq_full,
    input  logic             rob_head_valid,
    input  logic [TAG_W-1:0] rob_head_tag,
    input  logic             flush,
    output logic [XLEN-1:0]  proc2cache_addr,
    output logic [XLEN-1:0]  proc2cache_data,
    output logic [2:0]       proc2cache_size,
    output BUS_COMMAND       proc2cache_command,
    input  logic [XLEN-1:0]  cache2proc_data,
    input  logic             cache2proc_valid,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             store_done_valid,
    output logic [TAG_W-1:0] store_done_tag
);

    localparam int PTR_W = $clog2(LSQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsq_entry_t       mem_q [LSQ_DEPTH];
    lsq_entry_t       mem_d [LSQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    lsq_state_t       state_q, state_d;

    logic [XLEN-1:0]  req_addr_q, req_addr_d;
    logic [XLEN-1:0]  req_data_q, req_data_d;
    logic [2:0]       req_size_q, req_size_d;
    BUS_COMMAND       req_cmd_q, req_cmd_d;

    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]  cdb_data_q, cdb_data_d;
    logic             sd_valid_q, sd_valid_d;
    logic [TAG_W-1:0] sd_tag_q, sd_tag_d;

    lsq_entry_t       head_entry;
    logic [XLEN-1:0]  ext_data;
    logic             head_eligible;
    logic             push;
    logic             pop;
    logic             keep_store;

    assign head_entry = mem_q[head_q];
    assign lsq_full   = (count_q == CNT_W'(LSQ_DEPTH));

    load_data_extend u_extend (
        .raw_data    (cache2proc_data),
        .size        (head_entry.size),
        .is_unsigned (head_entry.unsigned_ld),
        .ext_data    (ext_data)
    );

    // Next-state logic: request FSM, completion reporting, queue pointers and flush.
    always_comb begin
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_size_d  = req_size_q;
        req_cmd_d   = req_cmd_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        sd_valid_d  = 1'b0;
        sd_tag_d    = sd_tag_q;
        pop         = 1'b0;
        keep_store  = 1'b0;

        push = dispatch_valid && !lsq_full && !flush;
        head_eligible = (count_q != '0) && head_entry.valid &&
                        (!head_entry.is_store ||
                         (rob_head_valid && (rob_head_tag == TAG_W'(head_entry.tag))));

        case (state_q)
            LSQ_IDLE: begin
                if (head_eligible && !flush) begin
                    req_addr_d = head_entry.addr;
                    req_data_d = head_entry.data;
                    req_size_d = head_entry.size;
                    req_cmd_d  = head_entry.is_store ? BUS_STORE : BUS_LOAD;
                    state_d    = LSQ_WAIT;
                end
            end
            LSQ_WAIT: begin
                if (cache2proc_valid) begin
                    req_cmd_d = BUS_NONE;
                    pop       = 1'b1;
                    state_d   = LSQ_IDLE;
                    if (head_entry.is_store) begin
                        sd_valid_d = 1'b1;
                        sd_tag_d   = TAG_W'(head_entry.tag);
                    end else if (!flush) begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = TAG_W'(head_entry.tag);
                        cdb_data_d  = ext_data;
                    end
                end else if (flush) begin
                    if (head_entry.is_store) begin
                        keep_store = 1'b1;
                    end else begin
                        state_d = LSQ_DRAIN;
                    end
                end
            end
            LSQ_DRAIN: begin
                if (cache2proc_valid) begin
                    req_cmd_d = BUS_NONE;
                    state_d   = LSQ_IDLE;
                end
            end
            default: state_d = LSQ_IDLE;
        endcase

        if (push) begin
            mem_d[tail_q] = '{valid:       1'b1,
                              is_store:    dispatch_is_store,
                              unsigned_ld: dispatch_unsigned,
                              size:        dispatch_size,
                              addr:        dispatch_addr,
                              data:        dispatch_data,
                              tag:         LSQ_TAG_W'(dispatch_tag)};
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            mem_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // A committed store already on the bus survives the squash as the
        // only entry, left at its current head slot.
        if (flush) begin
            for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
                if (!(keep_store && (PTR_W'(i) == head_q))) begin
                    mem_d[i].valid = 1'b0;
                end
            end
            if (keep_store) begin
                tail_d  = head_q + 1'b1;
                count_d = CNT_W'(1);
            end else begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= LSQ_IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_size_q  <= '0;
            req_cmd_q   <= BUS_NONE;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            sd_valid_q  <= 1'b0;
            sd_tag_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_size_q  <= req_size_d;
            req_cmd_q   <= req_cmd_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            sd_valid_q  <= sd_valid_d;
            sd_tag_q    <= sd_tag_d;
        end
    end

    assign proc2cache_addr    = req_addr_q;
    assign proc2cache_data    = req_data_q;
    assign proc2cache_size    = req_size_q;
    assign proc2cache_command = req_cmd_q;
    assign cdb_valid          = cdb_valid_q;
    assign cdb_tag            = cdb_tag_q;
    assign cdb_data           = cdb_data_q;
    assign store_done_valid   = sd_valid_q;
    assign store_done_tag     = sd_tag_q;

endmodule
